// File: rtl/reg_access_master.sv
// Initiator for the single-register write/read port: one host command at a time, one response each.
// Optional REG_WRITE_VERIFY_EN: every write is read back and a mismatch is flagged on rsp_err.
module reg_access_master #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned RD_LAT = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              reg_write_enable,
  output logic [DATA_W-1:0] reg_write_data,
  output logic              reg_read_enable,
  input  logic [DATA_W-1:0] reg_read_data,
  output logic              busy,
  output logic [7:0]        txn_count
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned TXN_W = 8;
  localparam logic [CNT_W-1:0] RD_LAT_C = CNT_W'(RD_LAT);

  typedef enum logic [1:0] {ST_IDLE, ST_WR, ST_RD, ST_RSP} state_t;

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] rd_cnt;
  logic             rd_done;
  logic             cmd_ready_nxt;
  logic             rsp_valid_nxt;
  logic             wen_nxt;
  logic             ren_nxt;
  logic             busy_nxt;
`ifdef REG_WRITE_VERIFY_EN
  logic             cmd_write_q;
`endif

  assign rd_done = (rd_cnt == '0);

  // State register; outputs are registered from the decoded next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= ST_IDLE;
      cmd_ready        <= 1'b1;
      rsp_valid        <= 1'b0;
      reg_write_enable <= 1'b0;
      reg_read_enable  <= 1'b0;
      busy             <= 1'b0;
    end else begin
      state            <= next_state;
      cmd_ready        <= cmd_ready_nxt;
      rsp_valid        <= rsp_valid_nxt;
      reg_write_enable <= wen_nxt;
      reg_read_enable  <= ren_nxt;
      busy             <= busy_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) next_state = cmd_write ? ST_WR : ST_RD;
      end
`ifdef REG_WRITE_VERIFY_EN
      ST_WR:   next_state = ST_RD;
`else
      ST_WR:   next_state = ST_RSP;
`endif
      ST_RD:   if (rd_done) next_state = ST_RSP;
      ST_RSP:  if (rsp_ready) next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Output decode of the state being entered.
  always_comb begin
    cmd_ready_nxt = 1'b0;
    rsp_valid_nxt = 1'b0;
    wen_nxt       = 1'b0;
    ren_nxt       = 1'b0;
    busy_nxt      = (next_state != ST_IDLE);
    case (next_state)
      ST_IDLE: cmd_ready_nxt = 1'b1;
      ST_WR:   wen_nxt       = 1'b1;
      ST_RD:   ren_nxt       = 1'b1;
      ST_RSP:  rsp_valid_nxt = 1'b1;
      default: cmd_ready_nxt = 1'b0;
    endcase
  end

  // Command latch, read-latency counter, response capture and transaction counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_cnt         <= '0;
      reg_write_data <= '0;
      rsp_rdata      <= '0;
      rsp_err        <= 1'b0;
      txn_count      <= '0;
`ifdef REG_WRITE_VERIFY_EN
      cmd_write_q    <= 1'b0;
`endif
    end else begin
      // reg_write_data doubles as the write-data latch so it holds between writes
      if (state == ST_IDLE && cmd_valid && cmd_ready) begin
`ifdef REG_WRITE_VERIFY_EN
        cmd_write_q <= cmd_write;
`endif
        if (cmd_write) reg_write_data <= cmd_wdata;
      end

      if (next_state == ST_RD && state != ST_RD) begin
        rd_cnt <= RD_LAT_C;
      end else if (state == ST_RD && !rd_done) begin
        rd_cnt <= rd_cnt - CNT_W'(1);
      end

      if (state == ST_WR && next_state == ST_RSP) begin
        rsp_rdata <= reg_write_data;
        rsp_err   <= 1'b0;
      end

      if (state == ST_RD && rd_done) begin
        rsp_rdata <= reg_read_data;
`ifdef REG_WRITE_VERIFY_EN
        rsp_err   <= cmd_write_q && (reg_read_data != reg_write_data);
`else
        rsp_err   <= 1'b0;
`endif
      end

      if (state == ST_RSP && rsp_ready) txn_count <= txn_count + TXN_W'(1);
    end
  end

endmodule

// File: tb/tb_reg_access_master.sv
// Self-checking bench for reg_access_master: directed scenarios plus random command mix
// checked against a per-command timing/data model.
module tb_reg_access_master;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned RD_LAT = 2;
`ifdef REG_WRITE_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  logic              clk;
  logic              reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              reg_write_enable;
  logic [DATA_W-1:0] reg_write_data;
  logic              reg_read_enable;
  logic [DATA_W-1:0] slave_data;
  logic              busy;
  logic [7:0]        txn_count;

  int         n_cmp;
  int         n_err;
  logic [7:0] model_cnt;
  logic [15:0] last_wd;

  reg_access_master #(.DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk              (clk),
    .reset            (reset),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_write        (cmd_write),
    .cmd_wdata        (cmd_wdata),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_rdata        (rsp_rdata),
    .rsp_err          (rsp_err),
    .reg_write_enable (reg_write_enable),
    .reg_write_data   (reg_write_data),
    .reg_read_enable  (reg_read_enable),
    .reg_read_data    (slave_data),
    .busy             (busy),
    .txn_count        (txn_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one command starting at a negedge; returns at the negedge after the response handshake.
  task automatic do_cmd(input logic wr, input logic [15:0] wd, input logic [15:0] rdv,
                        input int hold, input logic pend, input logic pend_wr,
                        input logic [15:0] pend_wd);
    int          lat;
    logic [15:0] exp_rd;
    logic        exp_err;
    logic        exp_wen;
    slave_data = rdv;
    cmd_valid  = 1'b1;
    cmd_write  = wr;
    cmd_wdata  = wd;
    rsp_ready  = 1'b0;
    check("cmd_ready_idle", cmd_ready, 1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    if (wr) last_wd = wd;
    lat     = wr ? (VERIFY ? RD_LAT + 2 : 1) : RD_LAT + 1;
    exp_rd  = (wr && !VERIFY) ? wd : rdv;
    exp_err = VERIFY && wr && (rdv != wd);
    for (int c = 1; c <= lat; c++) begin
      exp_wen = wr && (c == 1);
      check("write_enable", reg_write_enable, exp_wen);
      check("read_enable", reg_read_enable, !exp_wen);
      check("write_data", reg_write_data, last_wd);
      check("rsp_valid_early", rsp_valid, 0);
      check("cmd_ready_active", cmd_ready, 0);
      check("busy_active", busy, 1);
      @(negedge clk);
    end
    for (int h = 0; h <= hold; h++) begin
      check("rsp_valid", rsp_valid, 1);
      check("rsp_rdata", rsp_rdata, exp_rd);
      check("rsp_err", rsp_err, exp_err);
      check("enables_in_rsp", {reg_write_enable, reg_read_enable}, 0);
      check("cmd_ready_rsp", cmd_ready, 0);
      check("txn_before_hs", txn_count, model_cnt);
      if (h == hold) begin
        rsp_ready = 1'b1;
      end else if (pend) begin
        cmd_valid = 1'b1;
        cmd_write = pend_wr;
        cmd_wdata = pend_wd;
      end
      @(negedge clk);
    end
    rsp_ready = 1'b0;
    model_cnt = model_cnt + 8'd1;
    check("rsp_valid_after_hs", rsp_valid, 0);
    check("txn_count", txn_count, model_cnt);
    check("cmd_ready_after_hs", cmd_ready, 1);
    check("busy_idle", busy, 0);
  endtask

  initial begin
    logic        r_wr;
    logic [15:0] r_wd;
    logic [15:0] r_rd;
    n_cmp      = 0;
    n_err      = 0;
    model_cnt  = 8'd0;
    last_wd    = 16'd0;
    reset      = 1'b1;
    cmd_valid  = 1'b0;
    cmd_write  = 1'b0;
    cmd_wdata  = '0;
    rsp_ready  = 1'b0;
    slave_data = '0;

    repeat (2) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_outputs", {rsp_valid, rsp_err, reg_write_enable, reg_read_enable, busy}, 0);
    check("rst_rdata", rsp_rdata, 0);
    check("rst_wdata", reg_write_data, 0);
    check("rst_txn", txn_count, 0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_cmd_ready", cmd_ready, 1);

    // Write with no backpressure
    do_cmd(1'b1, 16'hA5A5, 16'h0F0F, 0, 1'b0, 1'b0, 16'h0);
    check("txn_first_write", txn_count, 1);

    // Read with RD_LAT latency
    do_cmd(1'b0, 16'h7777, 16'h1234, 0, 1'b0, 1'b0, 16'h0);

    // Backpressure with a second command pending
    do_cmd(1'b1, 16'h5A5A, 16'h0000, 5, 1'b1, 1'b0, 16'h3C3C);
    do_cmd(1'b0, 16'h3C3C, 16'hBEEF, 0, 1'b0, 1'b0, 16'h0);

    // Random command mix
    for (int i = 0; i < 30; i++) begin
      r_wr = 1'($urandom_range(0, 1));
      r_wd = 16'($urandom);
      r_rd = 16'($urandom);
      do_cmd(r_wr, r_wd, r_rd, int'($urandom_range(0, 3)), 1'b0, 1'b0, 16'h0);
    end

    // Reset during a read
    slave_data = 16'h4321;
    cmd_valid  = 1'b1;
    cmd_write  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("midrd_ren", reg_read_enable, 1);
    #1 reset = 1'b1;
    #1;
    check("midrd_ren_drop", reg_read_enable, 0);
    check("midrd_rsp_valid", rsp_valid, 0);
    check("midrd_txn", txn_count, 0);
    check("midrd_cmd_ready", cmd_ready, 1);
    model_cnt = 8'd0;
    last_wd   = 16'd0;
    repeat (2) @(negedge clk);
    check("rst_hold_cmd_ready", cmd_ready, 1);
    check("rst_hold_busy", busy, 0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_rel_cmd_ready", cmd_ready, 1);
    check("rst_rel_wdata", reg_write_data, 0);

    // 256 back-to-back reads wrap the counter
    for (int i = 0; i < 256; i++) begin
      r_rd = 16'($urandom);
      do_cmd(1'b0, 16'h0000, r_rd, int'($urandom_range(0, 1)), 1'b0, 1'b0, 16'h0);
    end
    check("txn_wrap", txn_count, 0);

`ifdef REG_WRITE_VERIFY_EN
    do_cmd(1'b1, 16'hFFFF, 16'h0000, 0, 1'b0, 1'b0, 16'h0);
    do_cmd(1'b1, 16'h00FF, 16'h00FF, 0, 1'b0, 1'b0, 16'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/reg_access_master.md
Name: reg_access_master

Overview:
- Initiator side of the 16-bit single-register write/read interface (write_enable/write_data, read_enable/read_data).
- Accepts one host command at a time over a valid/ready channel and drives the register port.
- Captures read data after a fixed read latency and returns one response per command over a valid/ready channel.
- Sits between a host/sequencer and any register slave on this interface.

Parameters:
- DATA_W, 16: width of command, register and response data.
- RD_LAT, 0: extra cycles from reg_read_enable rising to the reg_read_data sample point; legal range 0..15.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  host command present.
- cmd_ready  output  1  block can accept a command.
- cmd_write  input  1  1 = write, 0 = read.
- cmd_wdata  input  DATA_W  write data; ignored for reads.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  host accepts response.
- rsp_rdata  output  DATA_W  read data, or echoed write data.
- rsp_err  output  1  verify mismatch; only active with the optional feature.
- reg_write_enable  output  1  write strobe to slave.
- reg_write_data  output  DATA_W  write data to slave.
- reg_read_enable  output  1  read enable to slave.
- reg_read_data  input  DATA_W  read data from slave.
- busy  output  1  high whenever state is not IDLE.
- txn_count  output  8  completed responses, modulo 256.

Behaviour:
- Reset: clk is the only clock; reset is asynchronous and active-high.
  - While reset is high: state = IDLE, all outputs 0 except cmd_ready = 1, internal command latch 0, RD counter 0.
  - Reset mid-transaction aborts it. No response is produced, and the reg enables drop immediately (asynchronously).
- FSM states: IDLE, WR, RD, RSP.
- IDLE: cmd_ready = 1. On cmd_valid & cmd_ready at edge T, latch cmd_write and cmd_wdata.
  - Write -> WR.
  - Read -> RD with counter loaded with RD_LAT.
- WR (exactly 1 cycle): reg_write_enable = 1, reg_write_data = latched data.
  - Next state RSP, with rsp_rdata = latched data.
- RD: reg_read_enable = 1 for every RD cycle. Counter decrements each cycle.
  - When counter == 0, sample reg_read_data into rsp_rdata at that edge and go to RSP.
  - RD lasts RD_LAT+1 cycles.
- RSP: rsp_valid = 1. rsp_rdata and rsp_err are held stable until rsp_ready.
  - On the handshake edge: go to IDLE and increment txn_count (255 wraps to 0).
- cmd_ready = 0 in WR, RD and RSP. No command is accepted in the same cycle as a response handshake, so back-to-back throughput is one command per (latency+1) cycles.
- Latency, with command accepted at edge T:
  - Write: reg_write_enable high during cycle T+1; rsp_valid from cycle T+2.
  - Read: reg_read_enable high during cycles T+1..T+1+RD_LAT; rsp_valid from cycle T+2+RD_LAT.
- Default values:
  - reg_write_data holds its last value when not writing.
  - reg_write_enable and reg_read_enable are never high in the same cycle.
  - Both enables are 0 in IDLE and RSP.
- rsp_err is 0 unless the optional feature is compiled in.

Optional Feature:
- Macro: REG_WRITE_VERIFY_EN.
- Defined:
  - After WR, the FSM goes to RD instead of RSP, using the same RD_LAT timing.
  - At the sample edge, compare reg_read_data against the latched write data.
  - rsp_err = 1 on mismatch; rsp_rdata = the read-back value.
  - Write latency becomes T+3+RD_LAT to rsp_valid.
  - Read commands are unchanged, with rsp_err = 0.
- Undefined: rsp_err is tied to 0, and writes go WR -> RSP directly.

Test Plan:
- Write, no backpressure: after reset, write 0xA5A5 with rsp_ready = 1.
  - Required: reg_write_enable high exactly one cycle with reg_write_data = 0xA5A5.
  - Required: rsp_valid one cycle later with rsp_rdata = 0xA5A5; txn_count = 1.
- Read with latency: RD_LAT = 2, slave returns 0x1234 for a read command.
  - Required: reg_read_enable high for 3 cycles.
  - Required: rsp_valid at T+4 with rsp_rdata = 0x1234.
- Backpressure: rsp_ready held 0 for 5 cycles while a second cmd_valid is pending.
  - Required: rsp_valid and rsp_rdata stable, cmd_ready = 0, second command not accepted until the cycle after the handshake.
- Reset mid-read: assert reset during RD.
  - Required: reg_read_enable = 0 in the same cycle, rsp_valid = 0, txn_count = 0.
  - Required: cmd_ready = 1 while reset is held and after release.
- Counter wrap: 256 back-to-back reads.
  - Required: txn_count returns to 0x00, with no dropped or duplicated responses.
- Write verify, with REG_WRITE_VERIFY_EN defined:
  - Slave stuck at 0x0000, write 0xFFFF -> rsp_err = 1, rsp_rdata = 0x0000.
  - Correct slave, write 0x00FF -> rsp_err = 0, rsp_rdata = 0x00FF.
